pad_input_conditioner: RTL and testbench
========================================

Name: pad_input_conditioner

Overview:
- Sits directly downstream of the IO cells' TO_CORE outputs.
- Conditions each input-configured pad before core logic consumes it:
  - synchronises the asynchronous pad level into the core clock domain;
  - removes glitches with a programmable debounce counter;
  - detects rising and falling edges;
  - collects enabled edges into sticky interrupt status with one aggregated interrupt line.
- Pads configured as outputs (cell cfg bit 0 = 0) are ignored, because their TO_CORE value is constant 0.

Parameters:
- NUM_PADS, 8: number of pad channels.
- CNT_W, 8: debounce counter and limit width.
- SYNC_STAGES, 2: synchroniser flops per channel; legal range 2 to 4.

Ports:
- clk  input  1  core clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- pad_in  input  NUM_PADS  TO_CORE outputs of the IO cells; asynchronous.
- pad_is_input  input  NUM_PADS  copy of each cell's io_cell_cfg[0]; 1 = input mode.
- debounce_limit  input  CNT_W  stable cycles required before a level is accepted; shared by all channels.
- irq_en_rise  input  NUM_PADS  per-pad rising-edge interrupt enable.
- irq_en_fall  input  NUM_PADS  per-pad falling-edge interrupt enable.
- irq_clear  input  NUM_PADS  write-1-to-clear strobe for irq_status.
- pad_filt  output  NUM_PADS  debounced pad level.
- rise_pulse  output  NUM_PADS  one-cycle pulse on an accepted 0->1 transition.
- fall_pulse  output  NUM_PADS  one-cycle pulse on an accepted 1->0 transition.
- irq_status  output  NUM_PADS  sticky per-pad interrupt flags.
- irq  output  1  OR-reduction of irq_status, registered.

Behaviour:
- Reset values: all outputs 0; synchroniser flops 0; stable levels 0; counters 0.
- Synchroniser:
  - per channel, SYNC_STAGES flops in series; sync = last stage;
  - no other logic touches pad_in.
- Effective limit L:
  - L = max(debounce_limit, 1);
  - limit 0 and limit 1 both mean no filtering.
- Debounce, per channel, evaluated every clock:
  - sync == stable: cnt <= 0.
  - sync != stable and cnt >= L-1: stable <= sync, cnt <= 0.
  - otherwise: cnt <= cnt+1 (saturating at all-ones, which cannot be reached when L <= 2^CNT_W-1).
  - ">=" is used so that lowering debounce_limit mid-count accepts the new level immediately.
- Latency:
  - a level held steady at pad_in appears on pad_filt exactly SYNC_STAGES + L cycles after the first clock edge that samples it.
  - a disagreement lasting fewer than L cycles at sync is discarded; stable is unchanged.
- Edge detection:
  - rise_pulse = stable_next & ~stable, registered, so it is asserted in the same cycle pad_filt first shows 1;
  - fall_pulse is the mirror case.
  - Both are single-cycle and never asserted in the same cycle for the same pad.
- Output-mode pads (pad_is_input = 0):
  - synchroniser, stable and cnt are held at 0 (synchronous clear);
  - no pulses are generated;
  - irq_status is unaffected.
- Switching an output-mode pad to input:
  - the channel starts from 0;
  - a high pad therefore produces a normal rise_pulse after SYNC_STAGES + L cycles.
- Switching an input pad to output while stable = 1:
  - channel is cleared next cycle;
  - no fall_pulse.
- irq_status[i]:
  - set when (rise_pulse & irq_en_rise) | (fall_pulse & irq_en_fall);
  - otherwise cleared by irq_clear[i];
  - set wins over a simultaneous clear.
- irq: registered OR of irq_status; lags irq_status by one cycle.
- Reset asserted mid-count: all state clears on that edge; no pulses are issued on the reset cycle or the cycle after.

Optional Feature:
- Macro: PAD_COND_LEVEL_IRQ_EN.
- Defined:
  - adds inputs irq_level_mode [NUM_PADS] and irq_level_pol [NUM_PADS];
  - for pads with irq_level_mode = 1, irq_status is set every cycle that pad_filt == irq_level_pol and pad_is_input = 1;
  - irq_clear has effect only once the condition is false;
  - edge enables for that pad are ignored.
- Undefined: these ports are absent; only edge interrupts exist.

Decomposition:
- Package pad_cond_pkg:
  - default constants for NUM_PADS, CNT_W and SYNC_STAGES;
  - typedef pad_vec_t (logic [NUM_PADS-1:0]);
  - typedef struct ch_state_t {stable, cnt}.
- Sub-module pad_debounce_ch:
  - one channel containing synchroniser, counter, stable flop and edge pulses;
  - instantiated NUM_PADS times in a generate loop;
  - the top level holds irq_status, irq and the optional level logic.

Test Plan:
- Reset, then limit=4, pad 0 input, pad_in[0] 0->1 held -> pad_filt[0]=1 and rise_pulse[0]=1 exactly 2+4=6 cycles after the sampling edge; pulse lasts one cycle.
- limit=4, 3-cycle high glitch on pad_in[1] -> pad_filt[1] stays 0, no pulses, cnt returns to 0.
- limit=0 and limit=1 -> each pad_in change reaches pad_filt after exactly 3 cycles (SYNC_STAGES=2 + 1).
- irq_en_fall[2]=1, pad 2 falls -> irq_status[2]=1 with fall_pulse, irq=1 next cycle; irq_clear[2] asserted on the same cycle as a new fall -> irq_status[2] stays 1.
- pad_is_input[3]=0 while pad_in[3]=1 -> pad_filt[3]=0, no pulses; switch to input -> rise_pulse[3] after SYNC_STAGES+L cycles.
- PAD_COND_LEVEL_IRQ_EN: level mode, pol=1, pad high -> irq_clear ignored while high; clears after pad_filt returns to 0.

Source files
------------

// File: rtl/pad_cond_pkg.sv
// Shared constants and types for the pad input conditioner.
// Optional build macro used by the block: PAD_COND_LEVEL_IRQ_EN
// (adds level-sensitive interrupt mode).
package pad_cond_pkg;

    localparam int NUM_PADS_DEF    = 8;
    localparam int CNT_W_DEF       = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef logic [NUM_PADS_DEF-1:0] pad_vec_t;

    // Per-channel debounce state at the default counter width.
    typedef struct packed {
        logic                 stable;
        logic [CNT_W_DEF-1:0] cnt;
    } ch_state_t;

endpackage

// File: rtl/pad_input_conditioner_if.sv
// Bus bundle between the pad conditioner and its environment.
//   pad_in / pad_is_input      : raw pad levels and their input-mode flags
//   debounce_limit             : shared debounce limit
//   irq_en_rise / irq_en_fall  : edge interrupt enables
//   irq_clear                  : write-1-to-clear strobes for irq_status
//   pad_filt, rise_pulse, fall_pulse, irq_status, irq : conditioner outputs
//   irq_level_mode / irq_level_pol : only with PAD_COND_LEVEL_IRQ_EN defined
// master = environment side, slave = conditioner side.
interface pad_input_conditioner_if #(
    parameter int NUM_PADS = 8,
    parameter int CNT_W    = 8
);
    logic [NUM_PADS-1:0] pad_in;
    logic [NUM_PADS-1:0] pad_is_input;
    logic [CNT_W-1:0]    debounce_limit;
    logic [NUM_PADS-1:0] irq_en_rise;
    logic [NUM_PADS-1:0] irq_en_fall;
    logic [NUM_PADS-1:0] irq_clear;
`ifdef PAD_COND_LEVEL_IRQ_EN
    logic [NUM_PADS-1:0] irq_level_mode;
    logic [NUM_PADS-1:0] irq_level_pol;
`endif
    logic [NUM_PADS-1:0] pad_filt;
    logic [NUM_PADS-1:0] rise_pulse;
    logic [NUM_PADS-1:0] fall_pulse;
    logic [NUM_PADS-1:0] irq_status;
    logic                irq;

    modport master (
`ifdef PAD_COND_LEVEL_IRQ_EN
        output irq_level_mode, irq_level_pol,
`endif
        output pad_in, pad_is_input, debounce_limit,
        output irq_en_rise, irq_en_fall, irq_clear,
        input  pad_filt, rise_pulse, fall_pulse, irq_status, irq
    );

    modport slave (
`ifdef PAD_COND_LEVEL_IRQ_EN
        input  irq_level_mode, irq_level_pol,
`endif
        input  pad_in, pad_is_input, debounce_limit,
        input  irq_en_rise, irq_en_fall, irq_clear,
        output pad_filt, rise_pulse, fall_pulse, irq_status, irq
    );

endinterface

// File: rtl/pad_debounce_ch.sv
// One pad channel: synchroniser, debounce counter, stable level and
// registered edge pulses.
//   clk, rst    : core clock, synchronous active-high reset
//   pad_i       : asynchronous pad level
//   is_input_i  : 1 = pad in input mode; 0 holds the channel cleared
//   limit_i     : debounce limit (0 and 1 both mean no filtering)
//   filt_o      : debounced level
//   rise_o/fall_o     : registered one-cycle edge pulses
//   rise_d_o/fall_d_o : the same pulses one cycle early (next-state),
//                       so the parent can register status alongside them
module pad_debounce_ch #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2   // 2..4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pad_i,
    input  logic             is_input_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             filt_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             rise_d_o,
    output logic             fall_d_o
);

    typedef struct packed {
        logic             stable;
        logic [CNT_W-1:0] cnt;
    } cstate_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    cstate_t                st_q, st_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync;
    logic [CNT_W-1:0]       lim_m1;

    always_comb begin
        sync   = sync_q[SYNC_STAGES-1];
        // Effective limit is max(limit,1); compare against L-1.
        lim_m1 = (limit_i == '0) ? '0 : limit_i - CNT_W'(1);
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
        st_d   = st_q;

        if (sync == st_q.stable) begin
            st_d.cnt = '0;
        end else if (st_q.cnt >= lim_m1) begin
            // ">=" lets a lowered limit accept a pending level at once.
            st_d.stable = sync;
            st_d.cnt    = '0;
        end else if (st_q.cnt != '1) begin
            st_d.cnt = st_q.cnt + CNT_W'(1);
        end

        rise_d = st_d.stable & ~st_q.stable;
        fall_d = ~st_d.stable & st_q.stable;

        // Output-mode pads: whole channel held cleared, no pulses, so
        // leaving input mode with stable=1 never produces a fall.
        if (!is_input_i) begin
            sync_d = '0;
            st_d   = '0;
            rise_d = 1'b0;
            fall_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            st_q   <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            st_q   <= st_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign filt_o   = st_q.stable;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign rise_d_o = rise_d;
    assign fall_d_o = fall_d;

endmodule

// File: rtl/pad_input_conditioner.sv
// Pad input conditioner: per-pad synchronise/debounce/edge detect, plus
// sticky interrupt status and one registered aggregated interrupt.
//   clk, rst : core clock, synchronous active-high reset
//   pad_if   : slave side of pad_input_conditioner_if (all pad/irq signals)
// Build macro: PAD_COND_LEVEL_IRQ_EN adds level-sensitive interrupt mode
// (irq_level_mode / irq_level_pol in the interface).
module pad_input_conditioner
    import pad_cond_pkg::*;
#(
    parameter int NUM_PADS    = NUM_PADS_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input logic                     clk,
    input logic                     rst,
    pad_input_conditioner_if.slave  pad_if
);

    logic [NUM_PADS-1:0] filt;
    logic [NUM_PADS-1:0] rise, fall;
    logic [NUM_PADS-1:0] rise_nx, fall_nx;
    logic [NUM_PADS-1:0] set_v;
    logic [NUM_PADS-1:0] status_q, status_d;
    logic                irq_q, irq_d;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_ch
        pad_debounce_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pad_i      (pad_if.pad_in[g]),
            .is_input_i (pad_if.pad_is_input[g]),
            .limit_i    (pad_if.debounce_limit),
            .filt_o     (filt[g]),
            .rise_o     (rise[g]),
            .fall_o     (fall[g]),
            .rise_d_o   (rise_nx[g]),
            .fall_d_o   (fall_nx[g])
        );
    end

    always_comb begin
        // Status is set from next-state pulses so it rises together with
        // the registered pulse outputs.
        set_v = (rise_nx & pad_if.irq_en_rise) | (fall_nx & pad_if.irq_en_fall);
`ifdef PAD_COND_LEVEL_IRQ_EN
        // Level pads ignore edge enables and re-set every cycle the
        // condition holds, so a clear only sticks once it goes false.
        set_v = (set_v & ~pad_if.irq_level_mode)
              | (pad_if.irq_level_mode & pad_if.pad_is_input
                 & ~(filt ^ pad_if.irq_level_pol));
`endif
        status_d = set_v | (status_q & ~pad_if.irq_clear);
        irq_d    = |status_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign pad_if.pad_filt   = filt;
    assign pad_if.rise_pulse = rise;
    assign pad_if.fall_pulse = fall;
    assign pad_if.irq_status = status_q;
    assign pad_if.irq        = irq_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner (NUM_PADS=8, CNT_W=8,
// SYNC_STAGES=2). Inputs change 1 time unit after a rising edge; each row
// then advances n rising edges and compares outputs 1 unit after the last.
module tb_pad_input_conditioner;
    import pad_cond_pkg::*;

    typedef struct {
        logic     rst;
        pad_vec_t pin, isin;
        logic [7:0] lim;
        pad_vec_t enr, enf, clr;
        int       n;
        pad_vec_t filt, rise, fall, st;
        logic     irq;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl[31];

    always #5 clk = ~clk;

    pad_input_conditioner_if #(.NUM_PADS(8), .CNT_W(8)) pif();

    pad_input_conditioner #(
        .NUM_PADS(8), .CNT_W(8), .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pad_if (pif)
    );

    function automatic vec_t v(logic r, pad_vec_t pin, pad_vec_t isin, logic [7:0] lim,
                               pad_vec_t enr, pad_vec_t enf, pad_vec_t clr, int n,
                               pad_vec_t filt, pad_vec_t rise, pad_vec_t fall,
                               pad_vec_t st, logic irq);
        vec_t x;
        x.rst = r; x.pin = pin; x.isin = isin; x.lim = lim;
        x.enr = enr; x.enf = enf; x.clr = clr; x.n = n;
        x.filt = filt; x.rise = rise; x.fall = fall; x.st = st; x.irq = irq;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        //          rst pin    isin   lim    enr    enf    clr   n  filt   rise   fall   st     irq
        tbl[0]  = v(1, 8'h00, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 2, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        // pad0 rise, L=4: visible on the 6th edge from the sampling edge
        tbl[1]  = v(0, 8'h01, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 5, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[2]  = v(0, 8'h01, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h01, 8'h00, 8'h01, 0);
        tbl[3]  = v(0, 8'h01, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h01, 1);
        // pad1 3-cycle glitch is discarded
        tbl[4]  = v(0, 8'h03, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 3, 8'h01, 8'h00, 8'h00, 8'h01, 1);
        tbl[5]  = v(0, 8'h01, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 8, 8'h01, 8'h00, 8'h00, 8'h01, 1);
        // pad1 4-cycle pulse is accepted, then its fall likewise
        tbl[6]  = v(0, 8'h03, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 4, 8'h01, 8'h00, 8'h00, 8'h01, 1);
        tbl[7]  = v(0, 8'h01, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 2, 8'h03, 8'h02, 8'h00, 8'h01, 1);
        tbl[8]  = v(0, 8'h01, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 1, 8'h03, 8'h00, 8'h00, 8'h01, 1);
        tbl[9]  = v(0, 8'h01, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 3, 8'h01, 8'h00, 8'h02, 8'h01, 1);
        tbl[10] = v(0, 8'h01, 8'hF7, 8'd4, 8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h01, 1);
        // limit 0: 3-cycle latency
        tbl[11] = v(0, 8'h05, 8'hF7, 8'd0, 8'h01, 8'h00, 8'h00, 2, 8'h01, 8'h00, 8'h00, 8'h01, 1);
        tbl[12] = v(0, 8'h05, 8'hF7, 8'd0, 8'h01, 8'h00, 8'h00, 1, 8'h05, 8'h04, 8'h00, 8'h01, 1);
        // limit 1: pad2 fall with fall irq enabled
        tbl[13] = v(0, 8'h01, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h00, 2, 8'h05, 8'h00, 8'h00, 8'h01, 1);
        tbl[14] = v(0, 8'h01, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h00, 1, 8'h01, 8'h00, 8'h04, 8'h05, 1);
        tbl[15] = v(0, 8'h01, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h05, 1);
        tbl[16] = v(0, 8'h01, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h05, 1, 8'h01, 8'h00, 8'h00, 8'h00, 1);
        tbl[17] = v(0, 8'h01, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        // clear coinciding with a new fall: set wins
        tbl[18] = v(0, 8'h05, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h00, 3, 8'h05, 8'h04, 8'h00, 8'h00, 0);
        tbl[19] = v(0, 8'h01, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h00, 2, 8'h05, 8'h00, 8'h00, 8'h00, 0);
        tbl[20] = v(0, 8'h01, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h04, 1, 8'h01, 8'h00, 8'h04, 8'h04, 0);
        tbl[21] = v(0, 8'h01, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h04, 1);
        // pad3 high while output mode: ignored
        tbl[22] = v(0, 8'h09, 8'hF7, 8'd1, 8'h01, 8'h04, 8'h04, 4, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        // switch pad3 to input: starts from 0, rises after 2+4 edges
        tbl[23] = v(0, 8'h09, 8'hFF, 8'd4, 8'h01, 8'h04, 8'h00, 5, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        tbl[24] = v(0, 8'h09, 8'hFF, 8'd4, 8'h01, 8'h04, 8'h00, 1, 8'h09, 8'h08, 8'h00, 8'h00, 0);
        // back to output while stable=1: cleared, no fall pulse
        tbl[25] = v(0, 8'h09, 8'hF7, 8'd4, 8'h01, 8'h04, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        tbl[26] = v(0, 8'h09, 8'hF7, 8'd4, 8'h01, 8'h04, 8'h00, 1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        // reset mid-count, then everything restarts from 0
        tbl[27] = v(0, 8'h09, 8'hFF, 8'd4, 8'h01, 8'h04, 8'h00, 4, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        tbl[28] = v(1, 8'h09, 8'hFF, 8'd4, 8'h01, 8'h04, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[29] = v(0, 8'h09, 8'hFF, 8'd4, 8'h01, 8'h04, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[30] = v(0, 8'h09, 8'hFF, 8'd4, 8'h01, 8'h04, 8'h00, 5, 8'h09, 8'h09, 8'h00, 8'h01, 0);

        rst = 1'b1;
        pif.pad_in = '0; pif.pad_is_input = 8'hF7; pif.debounce_limit = 8'd4;
        pif.irq_en_rise = '0; pif.irq_en_fall = '0; pif.irq_clear = '0;
`ifdef PAD_COND_LEVEL_IRQ_EN
        pif.irq_level_mode = '0; pif.irq_level_pol = '0;
`endif
        step(1);

        for (int i = 0; i < 31; i++) begin
            rst                = tbl[i].rst;
            pif.pad_in         = tbl[i].pin;
            pif.pad_is_input   = tbl[i].isin;
            pif.debounce_limit = tbl[i].lim;
            pif.irq_en_rise    = tbl[i].enr;
            pif.irq_en_fall    = tbl[i].enf;
            pif.irq_clear      = tbl[i].clr;
            step(tbl[i].n);
            chk($sformatf("v%0d pad_filt", i),   pif.pad_filt,   tbl[i].filt);
            chk($sformatf("v%0d rise_pulse", i), pif.rise_pulse, tbl[i].rise);
            chk($sformatf("v%0d fall_pulse", i), pif.fall_pulse, tbl[i].fall);
            chk($sformatf("v%0d irq_status", i), pif.irq_status, tbl[i].st);
            chk($sformatf("v%0d irq", i),        {7'b0, pif.irq}, {7'b0, tbl[i].irq});
        end

        // Lowering the limit mid-count accepts the pending level next edge.
        pif.pad_in = 8'h0B; pif.debounce_limit = 8'd8;
        step(4);
        chk("limdrop before", pif.pad_filt, 8'h09);
        pif.debounce_limit = 8'd1;
        step(1);
        chk("limdrop filt", pif.pad_filt, 8'h0B);
        chk("limdrop rise", pif.rise_pulse, 8'h02);

        // Plain clear with no new event.
        pif.irq_clear = 8'h01;
        step(1);
        chk("clear pad0", pif.irq_status, 8'h00);
        pif.irq_clear = 8'h00;

`ifdef PAD_COND_LEVEL_IRQ_EN
        // Level mode, active high, pad0 currently high.
        pif.debounce_limit = 8'd4;
        pif.irq_level_mode = 8'h01; pif.irq_level_pol = 8'h01;
        step(1);
        chk("lvl set", {7'b0, pif.irq_status[0]}, 8'h01);
        pif.irq_clear = 8'h01;
        step(2);
        chk("lvl clr ignored", {7'b0, pif.irq_status[0]}, 8'h01);
        pif.pad_in = 8'h0A;
        step(6);
        chk("lvl filt low", {7'b0, pif.pad_filt[0]}, 8'h00);
        chk("lvl last set", {7'b0, pif.irq_status[0]}, 8'h01);
        step(1);
        chk("lvl cleared", {7'b0, pif.irq_status[0]}, 8'h00);
        pif.irq_clear = 8'h00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
